mips_mem_arbiter: RTL and testbench

MIPS_MEM_ARBITER -- requirements
Module: mips_mem_arbiter

---
 rtl/mips_mem_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_mips_mem_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter
//   Shares one single-ported memory between the instruction-fetch stage (IF)
//   and the data stage (ME). A three-state FSM (IDLE / IF_ACC / ME_ACC)
//   latches the winning request, drives the memory port for WAIT_CYCLES+1
//   cycles and then pulses the matching grant with the read data.
//   ME has priority over IF. Defining ARB_STARVE_GUARD_EN adds a starvation
//   guard that forces an IF grant after STARVE_LIMIT consecutive ME grants
//   made while a fetch is pending. Without the macro the priority is strict.
//
// Parameters
//   WAIT_CYCLES  : extra memory wait states per access (0..15)
//   STARVE_LIMIT : consecutive ME grants tolerated while IF waits (1..15)
// Ports
//   clk, reset                    : clock, synchronous active-high reset
//   if_req/if_addr                : fetch request (held until if_gnt)
//   if_gnt/if_rdata               : fetch completion pulse and fetched word
//   me_req/me_addr/me_rd_wr/me_wdata : data request (held until me_gnt)
//   me_gnt/me_rdata               : data completion pulse and load data
//   mem_en/mem_addr/mem_rd_wr/mem_wdata/mem_rdata : shared memory port
//   busy                          : FSM is not IDLE
// All outputs come straight from flops.
module mips_mem_arbiter #(
  parameter int unsigned WAIT_CYCLES  = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic [31:0] if_rdata,
  input  logic        me_req,
  input  logic [31:0] me_addr,
  input  logic        me_rd_wr,
  input  logic [31:0] me_wdata,
  output logic        me_gnt,
  output logic [31:0] me_rdata,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  output logic        mem_rd_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  if (WAIT_CYCLES > 15 || STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_param
    $error("mips_mem_arbiter: WAIT_CYCLES or STARVE_LIMIT out of range");
  end

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, IF_ACC, ME_ACC} state_t;

  state_t      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic        if_gnt_q, if_gnt_d;
  logic        me_gnt_q, me_gnt_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] me_rdata_q, me_rdata_d;
  logic        mem_en_q, mem_en_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        mem_rd_wr_q, mem_rd_wr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        busy_q, busy_d;

  // A requester whose grant is on the bus this cycle is still holding its
  // old request; it must not be served a second time.
  logic if_v, me_v, if_wins;
  assign if_v = if_req & ~if_gnt_q;
  assign me_v = me_req & ~me_gnt_q;

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  logic [3:0] starve_q, starve_d;
  // Raw me_req blocks IF even while masked, so a data stage that keeps
  // re-issuing holds strict priority; only the guard can break through.
  assign if_wins = if_v & (~me_req | (starve_q == STARVE_MAX));
`else
  assign if_wins = if_v & ~me_req;
`endif

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    if_gnt_d    = 1'b0;
    me_gnt_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    me_rdata_d  = me_rdata_q;
    mem_en_d    = mem_en_q;
    mem_addr_d  = mem_addr_q;
    mem_rd_wr_d = mem_rd_wr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef ARB_STARVE_GUARD_EN
    starve_d    = starve_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef ARB_STARVE_GUARD_EN
        if (!if_req) starve_d = 4'd0;
`endif
        // The access state and the memory strobe start on the same edge,
        // so the first mem_en cycle directly follows the arbitration cycle.
        if (if_wins) begin
          state_d     = IF_ACC;
          wait_d      = 4'd0;
          mem_en_d    = 1'b1;
          mem_addr_d  = if_addr;
          mem_rd_wr_d = 1'b1;
          mem_wdata_d = 32'd0;
`ifdef ARB_STARVE_GUARD_EN
          starve_d    = 4'd0;
`endif
        end else if (me_v) begin
          state_d     = ME_ACC;
          wait_d      = 4'd0;
          mem_en_d    = 1'b1;
          mem_addr_d  = me_addr;
          mem_rd_wr_d = me_rd_wr;
          mem_wdata_d = me_wdata;
`ifdef ARB_STARVE_GUARD_EN
          if (if_v) starve_d = starve_q + 4'd1;
`endif
        end
      end
      IF_ACC, ME_ACC: begin
        if (wait_q == WAIT_LAST) begin
          // mem_rdata is captured on the last strobe cycle.
          state_d  = IDLE;
          mem_en_d = 1'b0;
          if (state_q == IF_ACC) begin
            if_gnt_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end else begin
            me_gnt_d = 1'b1;
            if (mem_rd_wr_q) me_rdata_d = mem_rdata;
          end
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      default: begin
        state_d  = IDLE;
        mem_en_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wait_q      <= 4'd0;
      if_gnt_q    <= 1'b0;
      me_gnt_q    <= 1'b0;
      if_rdata_q  <= 32'd0;
      me_rdata_q  <= 32'd0;
      mem_en_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_rd_wr_q <= 1'b1;
      mem_wdata_q <= 32'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      if_gnt_q    <= if_gnt_d;
      me_gnt_q    <= me_gnt_d;
      if_rdata_q  <= if_rdata_d;
      me_rdata_q  <= me_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_wr_q <= mem_rd_wr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

`ifdef ARB_STARVE_GUARD_EN
  always_ff @(posedge clk) begin
    if (reset) starve_q <= 4'd0;
    else       starve_q <= starve_d;
  end
`endif

  assign if_gnt    = if_gnt_q;
  assign me_gnt    = me_gnt_q;
  assign if_rdata  = if_rdata_q;
  assign me_rdata  = me_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_addr  = mem_addr_q;
  assign mem_rd_wr = mem_rd_wr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Testbench for mips_mem_arbiter: directed scenarios plus randomized traffic
// from two independent requesters; grant data is checked by a monitor that
// pops expectations from per-requester queues.
module tb_mips_mem_arbiter;

  localparam int W  = 1;
  localparam int SL = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, me_req, me_rd_wr;
  logic [31:0] if_addr, me_addr, me_wdata;
  logic        if_gnt, me_gnt, mem_en, mem_rd_wr, busy;
  logic [31:0] if_rdata, me_rdata, mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int failures = 0;

  // Expected grant data, one queue per requester (each has one request
  // outstanding at a time, so per-requester order is FIFO).
  logic [31:0] if_exp[$];
  logic [31:0] me_exp[$];
  logic [31:0] last_read;   // model of me_rdata: last ME read result

  // Requests currently presented, used to validate what appears on the port.
  bit          if_pend = 0, me_pend = 0;
  logic [31:0] if_pa, me_pa, me_pwd;
  logic        me_prw;

  int          en_cnt = 0;
  logic [31:0] snap_addr, snap_wdata;
  logic        snap_rw;

  always #5 clk = ~clk;

  mips_mem_arbiter #(.WAIT_CYCLES(W), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdata(if_rdata),
    .me_req(me_req), .me_addr(me_addr), .me_rd_wr(me_rd_wr), .me_wdata(me_wdata),
    .me_gnt(me_gnt), .me_rdata(me_rdata),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rd_wr(mem_rd_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h8002_0000) return 32'h27BD_FFE8;
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  // Memory returns the true word only on the final strobe cycle of an access,
  // so sampling on any other cycle yields the wrong data.
  assign mem_rdata = (mem_en && en_cnt == W + 1) ? mem_model(mem_addr) : ~mem_model(mem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rand_if_addr();
    logic [31:0] r;
    r = $urandom;
    return {16'h8002, r[15:2], 2'b00};
  endfunction

  function automatic logic [31:0] rand_me_addr();
    logic [31:0] r;
    r = $urandom;
    return {12'h801, r[19:2], 2'b00};
  endfunction

  // Monitor: grant data against the scoreboard, and the memory port
  // against the requests currently presented.
  always @(negedge clk) begin
    if (reset) begin
      en_cnt <= 0;
    end else begin
      if (if_gnt) begin
        if (if_exp.size() == 0) check("if_gnt_unexpected", 32'd1, 32'd0);
        else check("if_rdata", if_rdata, if_exp.pop_front());
      end
      if (me_gnt) begin
        if (me_exp.size() == 0) check("me_gnt_unexpected", 32'd1, 32'd0);
        else check("me_rdata", me_rdata, me_exp.pop_front());
      end
      check("busy_vs_mem_en", {31'd0, busy}, {31'd0, mem_en});
      if (mem_en) begin
        if (en_cnt == 0) begin
          check("mem_start_match",
                {31'd0, (if_pend && mem_addr == if_pa && mem_rd_wr && mem_wdata == 32'd0) ||
                        (me_pend && mem_addr == me_pa && mem_rd_wr == me_prw && mem_wdata == me_pwd)},
                32'd1);
          snap_addr  <= mem_addr;
          snap_wdata <= mem_wdata;
          snap_rw    <= mem_rd_wr;
        end else begin
          check("mem_addr_stable", mem_addr, snap_addr);
          check("mem_wdata_stable", mem_wdata ^ {31'd0, mem_rd_wr ^ snap_rw}, snap_wdata);
        end
        en_cnt <= en_cnt + 1;
      end else begin
        if (en_cnt != 0) check("mem_en_length", 32'(en_cnt), 32'(W + 1));
        en_cnt <= 0;
      end
    end
  end

  // Drivers are entered 1 time unit after a rising edge.
  task automatic if_txn(input logic [31:0] a, input bit late, output int lat);
    bit got;
    if_addr = a; if_req = 1'b1; if_pa = a; if_pend = 1;
    if_exp.push_back(mem_model(a));
    lat = 0; got = 0;
    while (!got && lat < 200) begin
      @(posedge clk); #1; lat++;
      got = if_gnt;
    end
    if (!got) check("if_gnt_timeout", 32'd0, 32'd1);
    if (late) begin @(posedge clk); #1; end
    if_req = 1'b0; if_pend = 0; if_addr = $urandom;
  endtask

  task automatic me_txn(input logic [31:0] a, input logic rw, input logic [31:0] wd,
                        input bit late, output int lat);
    bit got;
    me_addr = a; me_rd_wr = rw; me_wdata = wd; me_req = 1'b1;
    me_pa = a; me_prw = rw; me_pwd = wd; me_pend = 1;
    if (rw) last_read = mem_model(a);
    me_exp.push_back(last_read);
    lat = 0; got = 0;
    while (!got && lat < 200) begin
      @(posedge clk); #1; lat++;
      got = me_gnt;
    end
    if (!got) check("me_gnt_timeout", 32'd0, 32'd1);
    if (late) begin @(posedge clk); #1; end
    me_req = 1'b0; me_pend = 0; me_wdata = $urandom;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_if_gnt"},    {31'd0, if_gnt},    32'd0);
    check({tag, "_me_gnt"},    {31'd0, me_gnt},    32'd0);
    check({tag, "_if_rdata"},  if_rdata,           32'd0);
    check({tag, "_me_rdata"},  me_rdata,           32'd0);
    check({tag, "_mem_en"},    {31'd0, mem_en},    32'd0);
    check({tag, "_mem_addr"},  mem_addr,           32'd0);
    check({tag, "_mem_wdata"}, mem_wdata,          32'd0);
    check({tag, "_mem_rd_wr"}, {31'd0, mem_rd_wr}, 32'd1);
    check({tag, "_busy"},      {31'd0, busy},      32'd0);
  endtask

  task automatic me_set(input logic [31:0] a);
    logic [31:0] wd;
    wd = $urandom;
    me_addr = a; me_rd_wr = 1'b1; me_wdata = wd; me_req = 1'b1;
    me_pa = a; me_prw = 1'b1; me_pwd = wd; me_pend = 1;
    last_read = mem_model(a);
    me_exp.push_back(last_read);
  endtask

  initial begin
    int lat_a, lat_b, me_cnt, if_at, exp_at;
    bit done;
    reset = 1'b1; if_req = 0; me_req = 0; me_rd_wr = 1; if_addr = 0; me_addr = 0; me_wdata = 0;
    last_read = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // Single fetch with the reference word.
    if_txn(32'h8002_0000, 0, lat_a);
    check("fetch_latency", 32'(lat_a), 32'(W + 2));
    $display("txn fetch addr=80020000 latency=%0d", lat_a);
    @(posedge clk); #1;

    // Simultaneous requests: ME first, IF right behind.
    fork
      if_txn(32'h8002_0010, 0, lat_b);
      me_txn(32'h8012_0000, 1'b1, 32'h0, 0, lat_a);
    join
    check("simul_me_latency", 32'(lat_a), 32'(W + 2));
    check("simul_if_latency", 32'(lat_b), 32'(2 * (W + 2)));
    $display("txn simultaneous me_lat=%0d if_lat=%0d", lat_a, lat_b);
    @(posedge clk); #1;

    // Write leaves me_rdata holding the previous read.
    me_txn(32'h8011_FFF8, 1'b0, 32'hDEAD_BEEF, 0, lat_a);
    check("write_latency", 32'(lat_a), 32'(W + 2));
    $display("txn write addr=8011fff8 latency=%0d", lat_a);
    @(posedge clk); #1;

    // Reset during the second strobe cycle of a fetch aborts it.
    if_addr = 32'h8002_0040; if_req = 1'b1; if_pa = if_addr; if_pend = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_pre_mem_en", {31'd0, mem_en}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; if_req = 1'b0; if_pend = 0;
    check_reset_vals("abort");
    last_read = 32'd0;
    repeat (5) begin @(posedge clk); #1; end
    if_txn(32'h8002_0080, 0, lat_a);
    check("post_abort_latency", 32'(lat_a), 32'(W + 2));
    $display("txn abort-then-fetch latency=%0d", lat_a);
    @(posedge clk); #1;

    // Continuous ME traffic with a pending fetch.
    if_addr = 32'h8002_0100; if_req = 1'b1; if_pa = if_addr; if_pend = 1;
    if_exp.push_back(mem_model(if_addr));
    me_set(rand_me_addr());
    me_cnt = 0; if_at = -1; done = 0;
    for (int t = 0; t < 300 && !done; t++) begin
      @(posedge clk); #1;
      if (if_gnt) begin if_at = me_cnt; if_req = 1'b0; if_pend = 0; end
      if (me_gnt) begin
        me_cnt++;
        if (me_cnt < 6) me_set(rand_me_addr());
        else begin me_req = 1'b0; me_pend = 0; end
      end
      done = (if_at >= 0) && (me_cnt >= 6);
    end
    check("starve_done", {31'd0, done}, 32'd1);
`ifdef ARB_STARVE_GUARD_EN
    exp_at = SL;
`else
    exp_at = 6;
`endif
    check("starve_me_before_if", 32'(if_at), 32'(exp_at));
    $display("txn starve me_gnts_before_if=%0d", if_at);
    @(posedge clk); #1;

    // Randomized traffic from both requesters.
    fork
      begin
        int l;
        for (int i = 0; i < 25; i++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          if_txn(rand_if_addr(), 1'($urandom_range(0, 1)), l);
          $display("txn rand if #%0d latency=%0d", i, l);
        end
      end
      begin
        int l;
        logic [31:0] wd;
        for (int i = 0; i < 25; i++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          wd = $urandom;
          me_txn(rand_me_addr(), 1'($urandom_range(0, 1)), wd, 1'($urandom_range(0, 1)), l);
          $display("txn rand me #%0d latency=%0d", i, l);
        end
      end
    join

    repeat (10) begin @(posedge clk); #1; end
    check("if_queue_drained", 32'(if_exp.size()), 32'd0);
    check("me_queue_drained", 32'(me_exp.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
